rv32i_seq_ctrl: RTL
===================

Name: rv32i_seq_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath selects: register-file and PC/IR write enables, ALU operation, operand muxes and the memory request handshake. It sits beside the immediate generator and takes the same instruction register contents. It also counts retired instructions and traps on illegal encodings or memory timeouts.

Parameters:
TIMEOUT, 15, maximum wait cycles for mem_ready in FETCH or MEM before a bus error is raised; 0 disables the timeout.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ir  in  32  instruction register contents; valid from DECODE onward
mem_ready  in  1  memory completes the current request this cycle
br_taken  in  1  datapath comparator result; sampled in EXEC for branches
mem_req  out  1  memory request
mem_we  out  1  store strobe, qualified by mem_req
mem_size  out  2  00 byte, 01 half, 10 word
addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 {alu[31:1],0}
rf_we  out  1  register file write
wb_sel  out  2  00 ALU, 01 load data, 10 PC+4, 11 imm
alu_a_sel  out  2  00 rs1, 01 PC, 10 zero
alu_b_sel  out  1  0 rs2, 1 imm
alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
instret  out  CNT_W  retired-instruction count
illegal  out  1  sticky illegal-instruction flag
bus_err  out  1  sticky memory-timeout flag
state  out  3  debug: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP

Behaviour:
- Decode fields: opcode = ir[6:0], funct3 = ir[14:12], funct7 = ir[31:25].
- All outputs are combinational from state and ir. Registered state: state, wait counter, instret, illegal, bus_err.
- Reset (synchronous, takes priority over everything):
  - state = FETCH, wait counter = 0, instret = 0, illegal = 0, bus_err = 0.
  - A reset mid-transaction abandons it. A store in MEM is not reissued.
- Default for every output in every state is 0.
- FETCH:
  - mem_req = 1, addr_sel = 0, mem_size = 10.
  - On mem_ready: ir_we = 1, go to DECODE.
- DECODE (1 cycle):
  - Classify the instruction and go to EXEC.
  - Go to TRAP with illegal = 1 on: unknown opcode; branch funct3 of 010 or 011; load funct3 of 011, 110 or 111; store funct3 > 010; OP funct7 other than 0x00, or 0x20 with funct3 other than 000/101; shift-immediate funct7 mismatch (SLLI/SRLI require 0x00, SRAI requires 0x20).
- EXEC:
  - R-type: alu_a_sel = 00, alu_b_sel = 0. alu_op from funct3/funct7. Go to WB.
  - I-type ALU: alu_b_sel = 1, same alu_op mapping. Go to WB.
  - LUI and JAL: go to WB.
  - AUIPC: alu_a_sel = 01, alu_b_sel = 1, ADD. Go to WB.
  - JALR: rs1 + imm, ADD. Go to WB.
  - Load/store: rs1 + imm, ADD. Go to MEM.
  - Branch: pc_we = 1, pc_sel = br_taken ? 01 : 00, alu_op = SUB (BEQ/BNE), SLT (BLT/BGE), SLTU (BLTU/BGEU). Retire, go to FETCH.
  - FENCE / FENCE.I: pc_we = 1, pc_sel = 00, retire, go to FETCH.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_size = funct3[1:0], mem_we = store. ALU controls are held as in EXEC.
  - On mem_ready: a load goes to WB. A store asserts pc_we with pc_sel = 00, retires and goes to FETCH.
- WB:
  - rf_we = 1, pc_we = 1, retire, go to FETCH.
  - wb_sel: 01 for loads, 10 for JAL/JALR, 11 for LUI, else 00.
  - pc_sel: 01 for JAL, 10 for JALR, else 00.
  - ALU controls are held as in EXEC.
- Retire:
  - instret increments by exactly 1 in the same cycle as the final pc_we of each instruction.
  - instret wraps modulo 2^CNT_W.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and on mem_ready, and increments on each waiting cycle.
  - If TIMEOUT != 0 and the counter equals TIMEOUT with mem_ready still low, go to TRAP with bus_err = 1.
  - mem_ready arriving in the same cycle as the limit wins; no error is raised.
- TRAP:
  - All strobes are 0. The block stays in TRAP until reset.
  - illegal and bus_err hold their values.

Test Plan:
- Reset, then ADDI (0x00500093) with mem_ready in the 1st FETCH cycle → states 0,1,2,4,0. rf_we high in WB only, alu_b_sel = 1, alu_op = 0. instret = 1 after 4 cycles.
- LW (0x0000A103) with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles with addr_sel = 1, mem_size = 10. WB has wb_sel = 01. instret = 1.
- BEQ with br_taken = 1, then BNE with br_taken = 0 → pc_sel = 01 then 00, each with a single pc_we in EXEC. No rf_we. instret increases by 2.
- Illegal opcode 0x0000007F → DECODE goes to TRAP, illegal = 1, no pc_we, instret unchanged. The block remains in TRAP until reset clears it.
- TIMEOUT = 15, mem_ready held low in FETCH → TRAP entered after 16 waiting cycles with bus_err = 1. A repeat run with mem_ready on the 16th cycle produces no error.
- Reset asserted during MEM of SW → next cycle state = FETCH, mem_we = 0, instret = 0.

Source files
------------

// File: rtl/rv32i_seq_ctrl_if.sv
// rtl/rv32i_seq_ctrl_if.sv - control/handshake bundle between the RV32I sequencer and its datapath
//
// Signals (direction seen from the sequencer, modport master):
//   ir        in   instruction register contents
//   mem_ready in   memory completes the current request this cycle
//   br_taken  in   branch comparator result
//   mem_req   out  memory request
//   mem_we    out  store strobe, qualified by mem_req
//   mem_size  out  00 byte, 01 half, 10 word
//   addr_sel  out  0 PC, 1 ALU result
//   ir_we     out  load IR from memory read data
//   pc_we     out  update PC
//   pc_sel    out  00 PC+4, 01 PC+imm, 10 {alu[31:1],0}
//   rf_we     out  register file write
//   wb_sel    out  00 ALU, 01 load data, 10 PC+4, 11 imm
//   alu_a_sel out  00 rs1, 01 PC, 10 zero
//   alu_b_sel out  0 rs2, 1 imm
//   alu_op    out  ALU operation code
interface rv32i_seq_ctrl_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [3:0]  alu_op;

  modport master (
    input  ir, mem_ready, br_taken,
    output mem_req, mem_we, mem_size, addr_sel, ir_we, pc_we, pc_sel,
           rf_we, wb_sel, alu_a_sel, alu_b_sel, alu_op
  );

  modport slave (
    output ir, mem_ready, br_taken,
    input  mem_req, mem_we, mem_size, addr_sel, ir_we, pc_we, pc_sel,
           rf_we, wb_sel, alu_a_sel, alu_b_sel, alu_op
  );
endinterface

// File: rtl/rv32i_seq_ctrl.sv
// rtl/rv32i_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb control sequencer for RV32I
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   dp          datapath control bundle (rv32i_seq_ctrl_if.master)
//   instret     retired-instruction count, wraps modulo 2^CNT_W
//   illegal     sticky illegal-instruction flag
//   bus_err     sticky memory-timeout flag
//   state       debug view: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP
module rv32i_seq_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  rv32i_seq_ctrl_if.master dp,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              retire;
  logic              set_illegal;
  logic              set_bus_err;
  logic              timed_out;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op, is_fence;
  logic bad_insn;

  logic [1:0] alu_a;
  logic       alu_b;
  logic [3:0] alu_op_c;

  assign opcode = dp.ir[6:0];
  assign funct3 = dp.ir[14:12];
  assign funct7 = dp.ir[31:25];
  assign state  = state_q;

  // alt selects SUB over ADD and SRA over SRL; it is ignored for the other funct3 values.
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    is_lui    = (opcode == OPC_LUI);
    is_auipc  = (opcode == OPC_AUIPC);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_branch = (opcode == OPC_BRANCH);
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_opimm  = (opcode == OPC_OPIMM);
    is_op     = (opcode == OPC_OP);
    is_fence  = (opcode == OPC_FENCE);
  end

  always_comb begin
    bad_insn = 1'b0;
    case (opcode)
      OPC_BRANCH: bad_insn = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD:   bad_insn = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OPC_STORE:  bad_insn = (funct3 > 3'b010);
      OPC_OP:     bad_insn = !((funct7 == 7'h00) ||
                               ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      OPC_OPIMM: begin
        // Only the shift forms constrain funct7; ADDI and friends use those bits as immediate.
        if (funct3 == 3'b001)
          bad_insn = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          bad_insn = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE: bad_insn = 1'b0;
      default:    bad_insn = 1'b1;
    endcase
  end

  // ALU controls depend only on the instruction, so EXEC, MEM and WB all present the same values.
  always_comb begin
    alu_a    = 2'b00;
    alu_b    = 1'b0;
    alu_op_c = ALU_ADD;
    if (is_op) begin
      alu_op_c = alu_map(funct3, funct7[5]);
    end else if (is_opimm) begin
      alu_b    = 1'b1;
      alu_op_c = alu_map(funct3, funct7[5] && (funct3 == 3'b101));
    end else if (is_auipc) begin
      alu_a = 2'b01;
      alu_b = 1'b1;
    end else if (is_jalr || is_load || is_store) begin
      alu_b = 1'b1;
    end else if (is_branch) begin
      if (!funct3[2])
        alu_op_c = ALU_SUB;
      else if (!funct3[1])
        alu_op_c = ALU_SLT;
      else
        alu_op_c = ALU_SLTU;
    end
  end

  // A limit hit while mem_ready is high is not an error: the ready branch is tested first.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    wait_inc     = 1'b0;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;
    dp.mem_req   = 1'b0;
    dp.mem_we    = 1'b0;
    dp.mem_size  = 2'b00;
    dp.addr_sel  = 1'b0;
    dp.ir_we     = 1'b0;
    dp.pc_we     = 1'b0;
    dp.pc_sel    = 2'b00;
    dp.rf_we     = 1'b0;
    dp.wb_sel    = 2'b00;
    dp.alu_a_sel = 2'b00;
    dp.alu_b_sel = 1'b0;
    dp.alu_op    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        dp.mem_req  = 1'b1;
        dp.mem_size = 2'b10;
        if (dp.mem_ready) begin
          dp.ir_we = 1'b1;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          set_bus_err = 1'b1;
          state_d     = S_TRAP;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_DECODE: begin
        if (bad_insn) begin
          set_illegal = 1'b1;
          state_d     = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        dp.alu_a_sel = alu_a;
        dp.alu_b_sel = alu_b;
        dp.alu_op    = alu_op_c;
        if (is_branch) begin
          dp.pc_we  = 1'b1;
          dp.pc_sel = dp.br_taken ? 2'b01 : 2'b00;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end else if (is_fence) begin
          dp.pc_we = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dp.alu_a_sel = alu_a;
        dp.alu_b_sel = alu_b;
        dp.alu_op    = alu_op_c;
        dp.mem_req   = 1'b1;
        dp.addr_sel  = 1'b1;
        dp.mem_size  = funct3[1:0];
        dp.mem_we    = is_store;
        if (dp.mem_ready) begin
          if (is_store) begin
            dp.pc_we = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          set_bus_err = 1'b1;
          state_d     = S_TRAP;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_WB: begin
        dp.alu_a_sel = alu_a;
        dp.alu_b_sel = alu_b;
        dp.alu_op    = alu_op_c;
        dp.rf_we     = 1'b1;
        dp.pc_we     = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
        if (is_load)
          dp.wb_sel = 2'b01;
        else if (is_jal || is_jalr)
          dp.wb_sel = 2'b10;
        else if (is_lui)
          dp.wb_sel = 2'b11;
        if (is_jal)
          dp.pc_sel = 2'b01;
        else if (is_jalr)
          dp.pc_sel = 2'b10;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase
  end

  // The wait counter is zero whenever the previous cycle was not a waiting cycle,
  // which covers both entry into FETCH/MEM and the cycle after mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_inc ? wait_cnt + WAIT_W'(1) : '0;
      if (retire)
        instret <= instret + CNT_W'(1);
      if (set_illegal)
        illegal <= 1'b1;
      if (set_bus_err)
        bus_err <= 1'b1;
    end
  end

endmodule
